fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard stall from the decode-stage hazard unit; holds the PC and the IF/ID register.
REQ-006 br_taken  input  1  redirect request from decode (branch/jump resolved).
REQ-007 br_target  input  32  redirect target address.
REQ-008 instr_in  input  32  instruction word from instruction memory, combinational read at pc_f.
REQ-009 pc_f  output  32  current fetch PC; drives instruction-memory address and the PC adder.
REQ-010 instr_d  output  32  IF/ID registered instruction.
REQ-011 pc_d  output  32  IF/ID registered PC of instr_d.
REQ-012 pc4_d  output  32  IF/ID registered pc_d+4 (link value).
REQ-013 valid_d  output  1  1 = instr_d is a real fetched instruction; 0 = bubble.
REQ-014 fetch_cnt  output  32  count of instructions captured into IF/ID with valid_d=1.

Function
REQ-015 The next PC SHALL be selected with priority: stall (hold) > br_taken (br_target with bits [1:0] forced to 00) > pc_f+4.
REQ-016 pc_f+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag raised.
REQ-017 With stall=1, pc_f, instr_d, pc_d, pc4_d, valid_d and fetch_cnt SHALL hold their values, regardless of br_taken.
REQ-018 With stall=0, IF/ID SHALL capture instr_in, pc_f and pc_f+4 on the rising edge, one-cycle latency from pc_f to instr_d.
REQ-019 stall and br_taken both high: the branch SHALL be ignored in that cycle; decode re-presents it after the stall releases.
REQ-020 fetch_cnt SHALL increment by 1 on each edge where IF/ID captures with resulting valid_d=1, and wrap at 2^32.
REQ-021 All outputs SHALL be registered except pc_f, which is the PC register output directly.

Reset
REQ-022 reset=1 SHALL immediately, independent of clk, set pc_f=RESET_PC, instr_d=NOP_WORD, pc_d=0, pc4_d=0, valid_d=0 and fetch_cnt=0.
REQ-023 Reset asserted mid-stall or mid-redirect SHALL discard the pending stall/redirect.
REQ-024 The first rising edge after reset deasserts SHALL fetch from RESET_PC.

Configuration
REQ-025 Macro BRANCH_DELAY_SLOT_EN defined: on br_taken=1 and stall=0, IF/ID SHALL capture the sequential instruction normally (delay slot executes, valid_d=1).
REQ-026 Macro BRANCH_DELAY_SLOT_EN undefined: on br_taken=1 and stall=0, IF/ID SHALL load instr_d=NOP_WORD, valid_d=0, pc_d/pc4_d = captured values, fetch_cnt unchanged (flush).
REQ-027 PC redirect timing per REQ-015 SHALL be identical in both configurations.

Verification
REQ-028 Reset then 3 free-running cycles, memory returning 0x11,0x22,0x33 -> pc_f 3000,3004,3008,300C; instr_d 0x11,0x22,0x33; fetch_cnt=3.
REQ-029 stall=1 for 2 cycles at pc_f=3008 -> pc_f, instr_d, pc_d and fetch_cnt unchanged for 2 edges, then resume at 300C.
REQ-030 br_taken=1, br_target=32'h0000_3102 at pc_f=3010 -> next pc_f=3100; with macro: instr_d=mem[3010], valid_d=1; without: instr_d=0, valid_d=0, fetch_cnt unchanged.
REQ-031 stall=1 and br_taken=1 same cycle -> PC held; release stall with br_taken=1 -> redirect taken on that edge.
REQ-032 RESET_PC=32'hFFFF_FFF8, 3 cycles -> pc_f FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-033 reset pulsed between clock edges while stall=1 -> outputs take reset values immediately; next edge fetches RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Define BRANCH_DELAY_SLOT_EN to let the sequential instruction after a taken branch execute.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        capture_valid;

  assign pc_plus4 = pc_f + 32'd4;

  // Stall outranks a redirect; decode re-presents the branch once the stall clears.
  always_comb begin
    pc_next = pc_plus4;
    if (stall)
      pc_next = pc_f;
    else if (br_taken)
      pc_next = {br_target[31:2], 2'b00};
  end

`ifdef BRANCH_DELAY_SLOT_EN
  assign capture_valid = 1'b1;
`else
  assign capture_valid = ~br_taken;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // The IF/ID register holds whenever decode is stalled; a flushed slot keeps its PCs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d   <= NOP_WORD;
      pc_d      <= '0;
      pc4_d     <= '0;
      valid_d   <= 1'b0;
      fetch_cnt <= '0;
    end else if (!stall) begin
      pc_d    <= pc_f;
      pc4_d   <= pc_plus4;
      valid_d <= capture_valid;
      if (capture_valid) begin
        instr_d   <= instr_in;
        fetch_cnt <= fetch_cnt + 32'd1;
      end else begin
        instr_d <= NOP_WORD;
      end
    end
  end

endmodule
